// File: rtl/mem_ula_seq.sv
// mem_ula_seq: command sequencer in front of the memory/ALU datapath.
// Accepts one LOAD or EXEC command at a time (start/busy/done handshake),
// drives the datapath control/address/data lines, captures the ALU output
// and counts completed commands.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, cmd_*             command request and its fields (sampled in IDLE)
//   s_ula                    ALU output coming back from the datapath
//   cs, we_mem_in,
//   we_resultado             datapath chip select and write enables
//   enderecoA/B,
//   endereco_saida,
//   dado_in, opcode          datapath address/data/opcode lines
//   busy, done               handshake status
//   result                   last ALU value captured by an EXEC
//   op_count                 completed-command counter (wraps)
module mem_ula_seq #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cmd_load,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr_a,
    input  logic [ADDR_W-1:0] cmd_addr_b,
    input  logic [ADDR_W-1:0] cmd_addr_dst,
    input  logic [DATA_W-1:0] cmd_dado,
    input  logic [DATA_W-1:0] s_ula,
    output logic              cs,
    output logic              we_mem_in,
    output logic              we_resultado,
    output logic [ADDR_W-1:0] enderecoA,
    output logic [ADDR_W-1:0] enderecoB,
    output logic [ADDR_W-1:0] endereco_saida,
    output logic [DATA_W-1:0] dado_in,
    output logic [2:0]        opcode,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(MEM_LAT - 1);

    state_t     state, state_nxt;
    logic [3:0] wait_cnt;
    logic       accept;

    // control outputs for the state being entered
    logic cs_d, we_mem_in_d, we_resultado_d, busy_d, done_d;

    assign accept = (state == S_IDLE) && start;

    // state register and READ wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            // READ always follows acceptance of an EXEC, so loading on
            // acceptance is the same as loading on READ entry
            if (accept)
                wait_cnt <= WAIT_INIT;
            else if (state == S_READ && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = cmd_load ? S_LOAD : S_READ;
            S_LOAD:  state_nxt = S_DONE;
            S_READ:  if (wait_cnt == 4'd0) state_nxt = S_WRITE;
            S_WRITE: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being
    // entered; this lines them up with the state they belong to.
    always_comb begin
        cs_d           = 1'b0;
        we_mem_in_d    = 1'b0;
        we_resultado_d = 1'b0;
        busy_d         = 1'b1;
        done_d         = 1'b0;
        case (state_nxt)
            S_IDLE:  busy_d         = 1'b0;
            S_LOAD:  begin cs_d = 1'b1; we_mem_in_d = 1'b1; end
            S_READ:  cs_d           = 1'b1;
            S_WRITE: begin cs_d = 1'b1; we_resultado_d = 1'b1; end
            S_DONE:  done_d         = 1'b1;
            default: busy_d         = 1'b0;
        endcase
    end

    // Output registers. The address/data/opcode registers double as the
    // latched command: loaded only on acceptance, held everywhere else.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs             <= 1'b0;
            we_mem_in      <= 1'b0;
            we_resultado   <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            enderecoA      <= '0;
            enderecoB      <= '0;
            endereco_saida <= '0;
            dado_in        <= '0;
            opcode         <= '0;
            result         <= '0;
            op_count       <= '0;
        end else begin
            cs           <= cs_d;
            we_mem_in    <= we_mem_in_d;
            we_resultado <= we_resultado_d;
            busy         <= busy_d;
            done         <= done_d;
            if (accept) begin
                enderecoA      <= cmd_addr_a;
                enderecoB      <= cmd_addr_b;
                endereco_saida <= cmd_addr_dst;
                dado_in        <= cmd_dado;
                opcode         <= cmd_op;
            end
            if (state == S_WRITE)
                result <= s_ula;
            if (state == S_DONE)
                op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_ula_seq.sv
// Self-checking bench for mem_ula_seq. Two instances: DUT 0 uses
// MEM_LAT=1/CNT_W=16, DUT 1 uses MEM_LAT=4/CNT_W=2. The reference model
// describes each command as a timeline derived from its total latency.
module tb_mem_ula_seq;
    localparam int AW = 9;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst[2];
    logic          start[2];
    logic          cmd_load[2];
    logic [2:0]    cmd_op[2];
    logic [AW-1:0] cmd_addr_a[2];
    logic [AW-1:0] cmd_addr_b[2];
    logic [AW-1:0] cmd_addr_dst[2];
    logic [DW-1:0] cmd_dado[2];
    logic [DW-1:0] s_ula[2];

    logic          cs[2];
    logic          we_mem_in[2];
    logic          we_resultado[2];
    logic [AW-1:0] enderecoA[2];
    logic [AW-1:0] enderecoB[2];
    logic [AW-1:0] endereco_saida[2];
    logic [DW-1:0] dado_in[2];
    logic [2:0]    opcode[2];
    logic          busy[2];
    logic          done[2];
    logic [DW-1:0] result[2];
    logic [15:0]   op_count[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int ML = (g == 0) ? 1 : 4;
        localparam int CW = (g == 0) ? 16 : 2;
        logic [CW-1:0] oc;
        mem_ula_seq #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(ML), .CNT_W(CW)) u_dut (
            .clk(clk), .rst(rst[g]), .start(start[g]), .cmd_load(cmd_load[g]),
            .cmd_op(cmd_op[g]), .cmd_addr_a(cmd_addr_a[g]), .cmd_addr_b(cmd_addr_b[g]),
            .cmd_addr_dst(cmd_addr_dst[g]), .cmd_dado(cmd_dado[g]), .s_ula(s_ula[g]),
            .cs(cs[g]), .we_mem_in(we_mem_in[g]), .we_resultado(we_resultado[g]),
            .enderecoA(enderecoA[g]), .enderecoB(enderecoB[g]),
            .endereco_saida(endereco_saida[g]), .dado_in(dado_in[g]), .opcode(opcode[g]),
            .busy(busy[g]), .done(done[g]), .result(result[g]), .op_count(oc)
        );
        assign op_count[g] = 16'(oc);
    end

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [DW-1:0] res_m[2];
    int            cnt_m[2];

    function automatic int mem_lat(int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic int cnt_mod(int i);
        return (i == 0) ? 65536 : 4;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(int i, string tag);
        chk({tag, "_cs"}, cs[i], 0);
        chk({tag, "_we_in"}, we_mem_in[i], 0);
        chk({tag, "_we_res"}, we_resultado[i], 0);
        chk({tag, "_addr"}, {enderecoA[i], enderecoB[i], endereco_saida[i]}, 0);
        chk({tag, "_dado_op"}, {dado_in[i], opcode[i]}, 0);
        chk({tag, "_busy_done"}, {busy[i], done[i]}, 0);
        chk({tag, "_result"}, result[i], 0);
        chk({tag, "_count"}, op_count[i], 0);
    endtask

    // Issue one command on DUT i and check every cycle until back in IDLE.
    // wv is the ALU value presented during the result-write cycle.
    // poke re-asserts start with altered fields through the whole command.
    task automatic run_cmd(int i, logic ld, logic [2:0] op, logic [AW-1:0] a,
                           logic [AW-1:0] b, logic [AW-1:0] d, logic [DW-1:0] dat,
                           logic [DW-1:0] wv, bit poke);
        int lat;
        lat = ld ? 2 : mem_lat(i) + 2;
        chk("pre_idle_busy", busy[i], 0);
        start[i] = 1'b1; cmd_load[i] = ld; cmd_op[i] = op;
        cmd_addr_a[i] = a; cmd_addr_b[i] = b; cmd_addr_dst[i] = d; cmd_dado[i] = dat;
        s_ula[i] = DW'($urandom);
        tick();
        start[i] = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            chk("cs", cs[i], (k < lat));
            chk("we_mem_in", we_mem_in[i], (ld && k == 1));
            chk("we_resultado", we_resultado[i], (!ld && k == lat - 1));
            chk("done", done[i], (k == lat));
            chk("busy", busy[i], 1);
            chk("addr_a", enderecoA[i], a);
            chk("addr_b", enderecoB[i], b);
            chk("addr_dst", endereco_saida[i], d);
            chk("dado_op", {dado_in[i], opcode[i]}, {dat, op});
            if (k == lat) chk("result", result[i], res_m[i]);
            if (poke) begin
                start[i] = 1'b1; cmd_load[i] = ~ld; cmd_op[i] = op + 3'd1;
                cmd_addr_a[i] = ~a; cmd_addr_b[i] = ~b; cmd_addr_dst[i] = ~d;
                cmd_dado[i] = ~dat;
            end
            if (!ld && k == lat - 1) begin
                s_ula[i] = wv;
                res_m[i] = wv;
            end else begin
                s_ula[i] = DW'($urandom);
            end
            tick();
        end
        start[i] = 1'b0;
        cnt_m[i] = (cnt_m[i] + 1) % cnt_mod(i);
        chk("post_busy", busy[i], 0);
        chk("post_done_cs", {done[i], cs[i]}, 0);
        chk("op_count", op_count[i], cnt_m[i]);
        chk("hold_addr_a", enderecoA[i], a);
        chk("hold_result", result[i], res_m[i]);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; cmd_load[i] = 1'b0; cmd_op[i] = '0;
            cmd_addr_a[i] = '0; cmd_addr_b[i] = '0; cmd_addr_dst[i] = '0;
            cmd_dado[i] = '0; s_ula[i] = '0; res_m[i] = '0; cnt_m[i] = 0;
        end
        tick();
        tick();
        chk_zero(0, "rst0");
        chk_zero(1, "rst1");
        rst[0] = 1'b0; rst[1] = 1'b0;
        tick();

        // directed commands
        run_cmd(0, 1'b1, 3'b000, 9'h000, 9'h000, 9'h000, 8'h04, 8'h00, 0);
        run_cmd(0, 1'b0, 3'b000, 9'h008, 9'h009, 9'h001, 8'h00, 8'h0C, 0);
        run_cmd(1, 1'b0, 3'b000, 9'h008, 9'h009, 9'h001, 8'h00, 8'h0C, 0);
        run_cmd(0, 1'b0, 3'b101, 9'h010, 9'h011, 9'h002, 8'h00, 8'h5A, 1);
        run_cmd(1, 1'b0, 3'b111, 9'h1F0, 9'h1F1, 9'h1FF, 8'h00, 8'hA5, 1);

        // reset in the middle of READ on the MEM_LAT=4 instance
        start[1] = 1'b1; cmd_load[1] = 1'b0; cmd_op[1] = 3'b011;
        cmd_addr_a[1] = 9'h0AA; cmd_addr_b[1] = 9'h0BB; cmd_addr_dst[1] = 9'h0CC;
        tick();
        start[1] = 1'b0;
        tick();
        rst[1] = 1'b1;
        tick();
        chk_zero(1, "mid_rst_a");
        tick();
        chk_zero(1, "mid_rst_b");
        rst[1] = 1'b0;
        res_m[1] = '0; cnt_m[1] = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("after_rst_idle", {we_resultado[1], we_mem_in[1], cs[1], busy[1]}, 0);
        end

        // back-to-back LOADs through the 2-bit counter wrap
        for (int n = 0; n < 5; n++)
            run_cmd(1, 1'b1, 3'($urandom), 9'($urandom), 9'($urandom), 9'($urandom),
                    8'($urandom), 8'h00, (n == 2));

        // randomized commands
        for (int n = 0; n < 40; n++) begin
            run_cmd(int'($urandom_range(0, 1)), 1'($urandom), 3'($urandom),
                    9'($urandom), 9'($urandom), 9'($urandom), 8'($urandom),
                    8'($urandom), bit'($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ula_seq.md
Name: mem_ula_seq

Overview:
- Command sequencer directly upstream of the memory/ALU datapath (mem_01).
- Accepts one command at a time through a start/busy/done handshake. A command is either LOAD (write one byte into input memory) or EXEC (read operands A/B, apply ALU opcode, write result to result memory).
- Drives the datapath's cs, write enables, addresses, data and opcode.
- Captures the ALU output and counts completed commands.

Parameters:
- ADDR_W, 9, address width of enderecoA/enderecoB/endereco_saida
- DATA_W, 8, data width
- MEM_LAT, 1, read latency of the datapath in cycles, legal range 1..15
- CNT_W, 16, width of completed-command counter

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  command request, sampled only in IDLE
- cmd_load  in  1  1 = LOAD command, 0 = EXEC command
- cmd_op  in  3  ALU opcode for EXEC
- cmd_addr_a  in  ADDR_W  operand A address (LOAD: write address)
- cmd_addr_b  in  ADDR_W  operand B address
- cmd_addr_dst  in  ADDR_W  result address for EXEC
- cmd_dado  in  DATA_W  byte to write for LOAD
- s_ula  in  DATA_W  ALU output from datapath
- cs  out  1  datapath chip select
- we_mem_in  out  1  input-memory write enable
- we_resultado  out  1  result-memory write enable
- enderecoA  out  ADDR_W  to datapath
- enderecoB  out  ADDR_W  to datapath
- endereco_saida  out  ADDR_W  to datapath
- dado_in  out  DATA_W  to datapath
- opcode  out  3  to datapath
- busy  out  1  high from the cycle after an accepted start until the cycle done is high, inclusive
- done  out  1  one-cycle completion pulse
- result  out  DATA_W  last captured s_ula (EXEC only)
- op_count  out  CNT_W  completed commands, wraps 2^CNT_W-1 -> 0

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a clk edge) forces state IDLE and all outputs to 0. This includes the address, data, opcode, result and op_count outputs. It applies in any state and aborts a command in flight with no write issued after the reset edge.
- States: IDLE, LOAD, READ, WRITE, DONE.
- IDLE:
  - Outputs cs=0 and both write enables 0.
  - On start=1, all cmd_* inputs are latched into command registers.
  - The addresses, dado_in and opcode outputs are updated from the latched command at this same edge.
  - Next state is LOAD if cmd_load=1, else READ.
- LOAD: cs=1 and we_mem_in=1 for exactly one cycle, with enderecoA=cmd_addr_a and dado_in=cmd_dado. Next state DONE.
- READ:
  - cs=1; enderecoA, enderecoB and opcode are held.
  - A wait counter loaded with MEM_LAT-1 on entry decrements each cycle; the FSM stays in READ for exactly MEM_LAT cycles.
  - Next state WRITE.
- WRITE:
  - cs=1, we_resultado=1 for exactly one cycle, endereco_saida=cmd_addr_dst.
  - result <= s_ula at the end of this cycle.
  - Next state DONE.
- DONE:
  - done=1, cs=0, and both write enables return to 0.
  - op_count increments at the end of this cycle.
  - Next state IDLE.
- Latency, counted from the edge that samples start:
  - LOAD: done high 2 cycles later.
  - EXEC: done high MEM_LAT+2 cycles later.
- start while busy is ignored, and command inputs changing during busy have no effect.
- start high in the cycle done is high is ignored.
- start sampled in IDLE the cycle after DONE is accepted, so back-to-back commands have 1 idle cycle between them.
- we_mem_in and we_resultado are never both 1 in the same cycle.
- Address, dado_in and opcode outputs hold their last values in IDLE. Only cs gates the datapath.
- All 8 opcodes are passed through unmodified.

Test Plan:
- Reset: assert rst 2 cycles mid-EXEC (in READ) -> next cycle all outputs 0, state IDLE, no we_resultado pulse, op_count=0.
- LOAD: start with cmd_load=1, cmd_addr_a=9'h000, cmd_dado=8'h04 -> one cycle we_mem_in=1, enderecoA=0, dado_in=8'h04, cs=1; done 2 cycles after start; op_count=1.
- EXEC (MEM_LAT=1): cmd_addr_a=9'h008, cmd_addr_b=9'h009, cmd_addr_dst=9'h001, cmd_op=3'b000, model s_ula=8'h0C -> READ 1 cycle, then we_resultado=1 with endereco_saida=9'h001; result=8'h0C; done 3 cycles after start.
- Latency: MEM_LAT=4, same EXEC -> READ lasts 4 cycles, done 6 cycles after start; busy high exactly 6 cycles.
- Ignored start: pulse start with a different cmd_addr_a while busy, and again in the DONE cycle -> no second command, latched addresses unchanged, op_count increments by 1 only.
- Wrap: CNT_W=2, run 5 LOAD commands back-to-back -> op_count sequence 1,2,3,0,1; one idle cycle between each done and the next we_mem_in.
